// File: rtl/sram_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its two requesters and the external SRAM.
//   vga_*  : VGA glyph/character read port (req/addr in, ack/rdata out)
//   cpu_*  : CPU data port (req/we/addr/wdata in, ack/rdata out)
//   sram_* : SRAM address/data, SRAM_CE/SRAM_OE/SRAM_WE active-low strobes, sram_dq_oe
//   busy   : arbiter not idle
// Modport slave is the arbiter side; modport master is the requester/SRAM side.
interface sram_arbiter_if #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned ADDRWIDTH = 16
);
  logic                 vga_req;
  logic [ADDRWIDTH-1:0] vga_addr;
  logic                 vga_ack;
  logic [DATAWIDTH-1:0] vga_rdata;

  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDRWIDTH-1:0] cpu_addr;
  logic [DATAWIDTH-1:0] cpu_wdata;
  logic                 cpu_ack;
  logic [DATAWIDTH-1:0] cpu_rdata;

  logic [ADDRWIDTH-1:0] sram_addr;
  logic [DATAWIDTH-1:0] sram_wdata;
  logic [DATAWIDTH-1:0] sram_rdata;
  logic                 sram_dq_oe;
  logic                 SRAM_CE;
  logic                 SRAM_OE;
  logic                 SRAM_WE;
  logic                 busy;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata,
    output vga_ack, vga_rdata, cpu_ack, cpu_rdata, sram_addr, sram_wdata, sram_dq_oe,
           SRAM_CE, SRAM_OE, SRAM_WE, busy
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata,
    input  vga_ack, vga_rdata, cpu_ack, cpu_rdata, sram_addr, sram_wdata, sram_dq_oe,
           SRAM_CE, SRAM_OE, SRAM_WE, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one external SRAM between the CPU data port and the VGA fetch port.
// One requester is granted at a time; the strobes are held for ACCESS_CYCLES cycles, followed
// by a single all-strobes-high release cycle carrying the owner's one-cycle ack.
// VGA has priority, but after CPU_STARVE_LIMIT consecutive VGA wins over a pending CPU request
// the CPU is forced through.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : sram_arbiter_if.slave (requester ports, SRAM pins, busy); all outputs registered
module sram_arbiter #(
  parameter int unsigned DATAWIDTH        = 16,
  parameter int unsigned ADDRWIDTH        = 16,
  parameter int unsigned ACCESS_CYCLES    = 2,  // 1..15
  parameter int unsigned CPU_STARVE_LIMIT = 4   // 1..15
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);

  localparam logic [3:0] CntLoad   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] StarveMax = 4'(CPU_STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StAccess, StRelease} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           starve_q, starve_d;
  logic                 op_we_q, op_we_d;      // latched op: 1 = write
  logic                 own_vga_q, own_vga_d;  // latched owner: 1 = VGA
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic [DATAWIDTH-1:0] vga_rdata_q, vga_rdata_d;
  logic [DATAWIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                 ce_n_q, ce_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic                 dq_oe_q, dq_oe_d;
  logic                 vga_ack_q, vga_ack_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic                 busy_q, busy_d;
  logic                 cpu_wins;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    op_we_d     = op_we_q;
    own_vga_d   = own_vga_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    vga_rdata_d = vga_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    vga_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;

    cpu_wins = bus.cpu_req && (!bus.vga_req || (starve_q == StarveMax));

    unique case (state_q)
      StIdle: begin
        // An idle sample with no CPU demand ends any starvation run.
        if (!bus.cpu_req) starve_d = '0;
        if (bus.vga_req || bus.cpu_req) begin
          state_d = StAccess;
          cnt_d   = CntLoad;
          if (cpu_wins) begin
            own_vga_d = 1'b0;
            op_we_d   = bus.cpu_we;
            addr_d    = bus.cpu_addr;
            wdata_d   = bus.cpu_wdata;
            starve_d  = '0;
          end else begin
            // VGA is read-only; sram_wdata keeps its last value.
            own_vga_d = 1'b1;
            op_we_d   = 1'b0;
            addr_d    = bus.vga_addr;
            if (bus.cpu_req && (starve_q != StarveMax)) starve_d = starve_q + 4'd1;
          end
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StRelease;
          if (!op_we_q) begin
            if (own_vga_q) vga_rdata_d = bus.sram_rdata;
            else           cpu_rdata_d = bus.sram_rdata;
          end
          vga_ack_d = own_vga_q;
          cpu_ack_d = !own_vga_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Strobes are registered, so they are derived from the state being entered.
    if (state_d == StAccess) begin
      ce_n_d  = 1'b0;
      oe_n_d  = op_we_d;
      we_n_d  = !op_we_d;
      dq_oe_d = op_we_d;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      starve_q    <= '0;
      op_we_q     <= 1'b0;
      own_vga_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      vga_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      op_we_q     <= op_we_d;
      own_vga_q   <= own_vga_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      vga_rdata_q <= vga_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      vga_ack_q   <= vga_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.SRAM_CE    = ce_n_q;
  assign bus.SRAM_OE    = oe_n_q;
  assign bus.SRAM_WE    = we_n_q;
  assign bus.vga_ack    = vga_ack_q;
  assign bus.vga_rdata  = vga_rdata_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.busy       = busy_q;

endmodule
